uart_command_decoder: RTL and testbench
=======================================

Name: uart_command_decoder

Overview:
- Consumes the one-cycle byte strobes produced by the UART receiver.
- Assembles fixed 4-byte command frames: SYNC, address, data, checksum.
- Emits a single-cycle command strobe with address/data to the register/control logic.
- Frames are discarded on a checksum error or an inter-byte timeout, and the discard is counted.

Parameters:
SYNC_BYTE, 8'h55, frame start marker.
TIMEOUT_CYCLES, 50_000, clock cycles allowed between bytes of one frame before the frame is abandoned; must be >= 2.

Ports:
clock  input  1  system clock; one clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
rx_valid  input  1  one-cycle strobe: rx_byte holds a newly received byte; every high cycle counts as one byte
rx_byte  input  8  received byte, sampled only when rx_valid=1
cmd_valid  output  1  one-cycle strobe: a checksum-correct command was received
cmd_address  output  8  address of the last good command; stable between strobes
cmd_data  output  8  data of the last good command; stable between strobes
error  output  1  one-cycle strobe: frame discarded (bad checksum or timeout)
error_count  output  8  number of discarded frames, saturating at 255
busy  output  1  high whenever state != IDLE

Behaviour:
- Interface: one clock. Reset is synchronous and active-high.
- Reset:
  - state=IDLE, all internal latches and the timeout counter = 0.
  - cmd_valid=0, cmd_address=0, cmd_data=0, error=0, error_count=0, busy=0.
  - Reset mid-frame discards the partial frame without an error pulse or count.
- States:
  - IDLE: on rx_valid with rx_byte==SYNC_BYTE, go to ADDRESS. Any other byte is silently ignored (no error).
  - ADDRESS: on rx_valid, latch rx_byte into addr_q and go to DATA. SYNC_BYTE here is an ordinary address; there is no resync.
  - DATA: on rx_valid, latch rx_byte into data_q and go to CHECKSUM.
  - CHECKSUM: on rx_valid, compare rx_byte with (addr_q + data_q) mod 256 (8-bit truncated sum, carry discarded). Always return to IDLE.
    - Match: cmd_address <= addr_q, cmd_data <= data_q, cmd_valid <= 1.
    - Mismatch: error <= 1, error_count increments unless already 255.
- Latency: cmd_valid/error are registered and go high in the cycle after the rx_valid cycle that completes or breaks the frame. They stay high for exactly 1 cycle.
- cmd_address/cmd_data change only on a good frame and in the same cycle cmd_valid rises.
- Timeout counter (width $clog2(TIMEOUT_CYCLES)+1):
  - Cleared on every rx_valid and held at 0 in IDLE.
  - Otherwise increments each cycle.
  - If the counter == TIMEOUT_CYCLES-1 in a non-IDLE state with rx_valid=0: go to IDLE, error <= 1, error_count increments (saturating).
  - Result: with the last accepted byte's rx_valid in cycle 0, error is high in cycle TIMEOUT_CYCLES+1 and busy is low from that cycle.
- Simultaneous rx_valid and timeout expiry: the byte wins. It is processed normally and the counter clears; no timeout is raised.
- A new frame may start in the cycle after CHECKSUM, i.e. while cmd_valid/error is still high. Back-to-back frames with no idle gap are legal.
- error_count at 255: stays 255, but error still pulses.
- busy is derived combinationally from state.

Test Plan:
1. Bytes 55 12 34 46 -> cmd_valid high for one cycle, one cycle after the 4th rx_valid; cmd_address=12, cmd_data=34; error never high; busy high from the cycle after the 55 until cmd_valid.
2. Bytes 00 FF 55 A0 01 A1 -> leading 00 FF ignored (busy stays 0, no error); one cmd_valid with A0/01.
3. Good frame 55 12 34 46, then 55 12 34 47 -> second frame gives one error pulse; error_count=1; cmd_address/cmd_data remain 12/34; no cmd_valid.
4. Timeout: 55 12, then no bytes (TIMEOUT_CYCLES=16 in bench) -> error high exactly 17 cycles after the 12 strobe; error_count=1; a following 55 12 34 46 decodes normally. Variant: a byte arriving exactly on the expiry cycle is accepted and gives no error.
5. Wrap and back-to-back: 55 FF 02 01 immediately followed by 55 80 80 00 -> two cmd_valid strobes (FF/02, then 80/80), no errors.
6. Reset and saturation:
   - Assert reset after 55 12, then send 34 46 -> no cmd_valid, busy 0, error_count 0.
   - Then 260 frames with bad checksum -> 260 error pulses; error_count reaches 255 and holds.

Source files
------------

// File: rtl/uart_command_decoder_if.sv
// Byte-strobe input and decoded-command output bundle for uart_command_decoder.
// Ports: rx_valid/rx_byte (receiver -> decoder), cmd_valid/cmd_address/cmd_data,
//        error/error_count/busy (decoder -> register/control logic).
interface uart_command_decoder_if;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       cmd_valid;
    logic [7:0] cmd_address;
    logic [7:0] cmd_data;
    logic       error;
    logic [7:0] error_count;
    logic       busy;

    // master: the side feeding bytes and consuming commands
    modport master (
        output rx_valid, rx_byte,
        input  cmd_valid, cmd_address, cmd_data, error, error_count, busy
    );

    // slave: the decoder itself
    modport slave (
        input  rx_valid, rx_byte,
        output cmd_valid, cmd_address, cmd_data, error, error_count, busy
    );
endinterface

// File: rtl/uart_command_decoder.sv
// Purpose: assemble SYNC/address/data/checksum frames from UART byte strobes into commands.
// Latency: cmd_valid/error rise one cycle after the completing/breaking byte, 1-cycle pulses.
// Backpressure: none; every rx_valid cycle is consumed as a byte, no stall is possible.
// Ports: clock, reset (sync, active-high); bus (slave modport): rx_valid/rx_byte in,
//        cmd_valid/cmd_address/cmd_data, error/error_count, busy out.
module uart_command_decoder #(
    parameter logic [7:0] SYNC_BYTE      = 8'h55,
    parameter int         TIMEOUT_CYCLES = 50_000
) (
    input  logic                  clock,
    input  logic                  reset,
    uart_command_decoder_if.slave bus
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ADDRESS  = 2'd1,
        DATA     = 2'd2,
        CHECKSUM = 2'd3
    } state_t;

    state_t           state;
    logic [7:0]       addr_q;
    logic [7:0]       data_q;
    logic [CNT_W-1:0] tmo_cnt;
    logic             cmd_vld_q;
    logic [7:0]       cmd_addr_q;
    logic [7:0]       cmd_dat_q;
    logic             err_vld_q;
    logic [7:0]       err_cnt_q;

    logic [7:0]       csum_exp;
    logic             tmo_hit;

    // 8-bit truncated sum; carry intentionally dropped
    assign csum_exp = addr_q + data_q;

    // A byte arriving on the expiry cycle takes priority, hence the !rx_valid term
    assign tmo_hit  = (state != IDLE) && !bus.rx_valid && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= 8'd0;
            data_q     <= 8'd0;
            tmo_cnt    <= '0;
            cmd_vld_q  <= 1'b0;
            cmd_addr_q <= 8'd0;
            cmd_dat_q  <= 8'd0;
            err_vld_q  <= 1'b0;
            err_cnt_q  <= 8'd0;
        end else begin
            cmd_vld_q <= 1'b0;
            err_vld_q <= 1'b0;

            // Inter-byte gap counter: idle frames and fresh bytes restart it
            if (state == IDLE || bus.rx_valid) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (tmo_hit) begin
                state     <= IDLE;
                err_vld_q <= 1'b1;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_q <= err_cnt_q + 8'd1;
                end
            end else if (bus.rx_valid) begin
                case (state)
                    IDLE: begin
                        // non-SYNC bytes between frames are dropped silently
                        if (bus.rx_byte == SYNC_BYTE) begin
                            state <= ADDRESS;
                        end
                    end
                    ADDRESS: begin
                        // SYNC value here is just an address, no resync
                        addr_q <= bus.rx_byte;
                        state  <= DATA;
                    end
                    DATA: begin
                        data_q <= bus.rx_byte;
                        state  <= CHECKSUM;
                    end
                    CHECKSUM: begin
                        state <= IDLE;
                        if (bus.rx_byte == csum_exp) begin
                            cmd_vld_q  <= 1'b1;
                            cmd_addr_q <= addr_q;
                            cmd_dat_q  <= data_q;
                        end else begin
                            err_vld_q <= 1'b1;
                            if (err_cnt_q != 8'hFF) begin
                                err_cnt_q <= err_cnt_q + 8'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.cmd_valid   = cmd_vld_q;
    assign bus.cmd_address = cmd_addr_q;
    assign bus.cmd_data    = cmd_dat_q;
    assign bus.error       = err_vld_q;
    assign bus.error_count = err_cnt_q;
    assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_uart_command_decoder.sv
module tb_uart_command_decoder;

    localparam int         T    = 16;
    localparam logic [7:0] SYNC = 8'h55;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    uart_command_decoder_if ifc ();

    uart_command_decoder #(
        .SYNC_BYTE      (SYNC),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc.slave)
    );

    int checks   = 0;
    int failures = 0;
    int cmd_seen = 0;
    int err_seen = 0;

    // ---------------- behavioural model ----------------
    // A frame is the list of bytes collected since SYNC; the frame is judged
    // when it reaches four bytes, or abandoned once T cycles pass since its last byte.
    int         fr[$];
    int         cyc      = 0;
    int         last_cyc = 0;
    logic       e_vld    = 1'b0;
    logic       e_err    = 1'b0;
    logic       e_busy   = 1'b0;
    logic [7:0] e_addr   = 8'd0;
    logic [7:0] e_data   = 8'd0;
    int         e_cnt    = 0;

    always @(posedge clock) begin
        cyc++;
        e_vld = 1'b0;
        e_err = 1'b0;
        if (reset) begin
            fr.delete();
            e_addr = 8'd0;
            e_data = 8'd0;
            e_cnt  = 0;
        end else if (ifc.rx_valid) begin
            if (fr.size() > 0 || ifc.rx_byte == SYNC) fr.push_back(int'(ifc.rx_byte));
            last_cyc = cyc;
            if (fr.size() == 4) begin
                if (((fr[1] + fr[2]) % 256) == fr[3]) begin
                    e_vld  = 1'b1;
                    e_addr = 8'(fr[1]);
                    e_data = 8'(fr[2]);
                end else begin
                    e_err = 1'b1;
                    if (e_cnt < 255) e_cnt++;
                end
                fr.delete();
            end
        end else if (fr.size() > 0 && (cyc - last_cyc) == T) begin
            e_err = 1'b1;
            if (e_cnt < 255) e_cnt++;
            fr.delete();
        end
        e_busy = (fr.size() != 0);
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (cyc > 0) begin
            checks++;
            if ({ifc.cmd_valid, ifc.cmd_address, ifc.cmd_data, ifc.error, ifc.error_count, ifc.busy} !==
                {e_vld, e_addr, e_data, e_err, 8'(e_cnt), e_busy}) begin
                failures++;
                $display("FAIL model_cycle%0d got vld=%b addr=%h data=%h err=%b cnt=%0d busy=%b want vld=%b addr=%h data=%h err=%b cnt=%0d busy=%b",
                         cyc, ifc.cmd_valid, ifc.cmd_address, ifc.cmd_data, ifc.error, ifc.error_count, ifc.busy,
                         e_vld, e_addr, e_data, e_err, e_cnt, e_busy);
            end
            if (ifc.cmd_valid === 1'b1) cmd_seen++;
            if (ifc.error === 1'b1) err_seen++;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d (0x%0h) want=%0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        ifc.rx_valid = 1'b1;
        ifc.rx_byte  = b;
        @(posedge clock);
        #1;
        ifc.rx_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    int n_cmd, n_err, k, found;
    logic [7:0] a, d, c;

    initial begin
        ifc.rx_valid = 1'b0;
        ifc.rx_byte  = 8'h00;
        idle(3);
        chk("reset_outputs", int'({ifc.cmd_valid, ifc.cmd_address, ifc.cmd_data, ifc.error, ifc.error_count, ifc.busy}), 0);
        reset = 1'b0;

        // 1: basic frame
        n_cmd = cmd_seen; n_err = err_seen;
        send(8'h55);
        chk("t1_busy_after_sync", int'(ifc.busy), 1);
        send(8'h12); send(8'h34); send(8'h46);
        chk("t1_cmd_valid", int'(ifc.cmd_valid), 1);
        chk("t1_addr", int'(ifc.cmd_address), 8'h12);
        chk("t1_data", int'(ifc.cmd_data), 8'h34);
        idle(2);
        chk("t1_cmd_pulses", cmd_seen - n_cmd, 1);
        chk("t1_no_error", err_seen - n_err, 0);

        // 2: junk before SYNC
        n_err = err_seen;
        send(8'h00); send(8'hFF);
        chk("t2_busy_junk", int'(ifc.busy), 0);
        send(8'h55); send(8'hA0); send(8'h01); send(8'hA1);
        chk("t2_cmd_valid", int'(ifc.cmd_valid), 1);
        chk("t2_addr_data", int'({ifc.cmd_address, ifc.cmd_data}), 16'hA001);
        idle(1);
        chk("t2_no_error", err_seen - n_err, 0);

        // 3: good then bad checksum
        pulse_reset();
        send(8'h55); send(8'h12); send(8'h34); send(8'h46);
        n_cmd = cmd_seen;
        send(8'h55); send(8'h12); send(8'h34); send(8'h47);
        chk("t3_error", int'(ifc.error), 1);
        chk("t3_err_count", int'(ifc.error_count), 1);
        chk("t3_addr_data_held", int'({ifc.cmd_address, ifc.cmd_data}), 16'h1234);
        idle(2);
        chk("t3_no_cmd", cmd_seen - n_cmd, 1);

        // 4: timeout latency
        pulse_reset();
        send(8'h55); send(8'h12);
        found = 0;
        for (k = 1; k <= 3 * T && found == 0; k++) begin
            if (ifc.error === 1'b1) found = k;
            else idle(1);
        end
        chk("t4_timeout_cycle", found, T + 1);
        chk("t4_busy_low", int'(ifc.busy), 0);
        chk("t4_err_count", int'(ifc.error_count), 1);
        send(8'h55); send(8'h12); send(8'h34); send(8'h46);
        chk("t4_recover_cmd", int'(ifc.cmd_valid), 1);
        // byte landing on the expiry cycle wins
        n_err = err_seen;
        send(8'h55); send(8'h12);
        idle(T - 1);
        send(8'h34); send(8'h46);
        chk("t4_edge_cmd", int'(ifc.cmd_valid), 1);
        idle(1);
        chk("t4_edge_no_error", err_seen - n_err, 0);

        // 5: wraparound sum, back-to-back frames
        n_err = err_seen;
        send(8'h55); send(8'hFF); send(8'h02); send(8'h01);
        chk("t5_first", int'({ifc.cmd_valid, ifc.cmd_address, ifc.cmd_data}), 17'h1FF02);
        send(8'h55); send(8'h80); send(8'h80); send(8'h00);
        chk("t5_second", int'({ifc.cmd_valid, ifc.cmd_address, ifc.cmd_data}), 17'h18080);
        idle(1);
        chk("t5_no_error", err_seen - n_err, 0);

        // 6: reset mid-frame, then saturation
        pulse_reset();
        n_cmd = cmd_seen; n_err = err_seen;
        send(8'h55); send(8'h12);
        pulse_reset();
        send(8'h34); send(8'h46);
        idle(2);
        chk("t6_no_cmd_after_reset", cmd_seen - n_cmd, 0);
        chk("t6_busy", int'(ifc.busy), 0);
        chk("t6_count_zero", int'(ifc.error_count), 0);
        n_err = err_seen;
        for (int i = 0; i < 260; i++) begin
            send(8'h55); send(8'h01); send(8'h02); send(8'h00);
        end
        idle(2);
        chk("t6_error_pulses", err_seen - n_err, 260);
        chk("t6_saturated", int'(ifc.error_count), 255);

        // random: frames with corruption, junk, long gaps, occasional reset
        pulse_reset();
        for (int f = 0; f < 400; f++) begin
            if ($urandom_range(0, 7) == 0) send(8'($urandom_range(0, 255)));
            a = 8'($urandom_range(0, 255));
            d = 8'($urandom_range(0, 255));
            c = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'(a + d);
            for (int b = 0; b < 4; b++) begin
                case (b)
                    0: send(SYNC);
                    1: send(a);
                    2: send(d);
                    default: send(c);
                endcase
                if ($urandom_range(0, 9) == 0) idle($urandom_range(T - 2, T + 2));
                else if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 3));
                if ($urandom_range(0, 99) == 0) pulse_reset();
            end
        end
        idle(T + 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
